tt_um_top: RTL and testbench

Top-level Tiny Tapeout user block: an 8-bit accumulator ALU driven through the standard TT pin interface. Each rising edge on a strobe pin executes one of 16 opcodes on the accumulator A and the operand on `ui_in`. The result appears on `uo_out`, and the carry, zero and done flags appear on the upper bidirectional pins.

---
 rtl/tt_um_top.sv | 149 ++++++++++++++
 tb/tb_tt_um_top.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_top.sv
// 8-bit accumulator ALU behind the Tiny Tapeout pin interface.
// Each rising edge of the strobe pin executes one opcode on A and B.
module tt_um_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLoad = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpAdc  = 4'h3;
  localparam logic [3:0] OpSub  = 4'h4;
  localparam logic [3:0] OpSbb  = 4'h5;
  localparam logic [3:0] OpAnd  = 4'h6;
  localparam logic [3:0] OpOr   = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpNot  = 4'h9;
  localparam logic [3:0] OpShl  = 4'hA;
  localparam logic [3:0] OpShr  = 4'hB;
  localparam logic [3:0] OpRol  = 4'hC;
  localparam logic [3:0] OpRor  = 4'hD;
  localparam logic [3:0] OpInc  = 4'hE;
  localparam logic [3:0] OpClr  = 4'hF;

  logic [3:0] op;
  logic [7:0] opb;
  logic       stb;
  logic       exec;

  logic       stb_q;
  logic [7:0] acc_q, acc_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       done_q;

  logic [7:0] res;
  logic       carry;
  logic       upd_z;
  logic [8:0] sum9;

  assign op   = uio_in[3:0];
  assign stb  = uio_in[4];
  assign opb  = ui_in;
  assign exec = ena & stb & ~stb_q;

  logic unused_pins;
  assign unused_pins = ^uio_in[7:5];

  // ALU: res/carry default to the current state so non-affecting ops fall through.
  always_comb begin
    res   = acc_q;
    carry = c_q;
    upd_z = 1'b1;
    sum9  = '0;
    unique case (op)
      OpNop:  upd_z = 1'b0;
      OpLoad: res = opb;
      OpAdd: begin
        sum9  = {1'b0, acc_q} + {1'b0, opb};
        res   = sum9[7:0];
        carry = sum9[8];
      end
      OpAdc: begin
        sum9  = {1'b0, acc_q} + {1'b0, opb} + {8'b0, c_q};
        res   = sum9[7:0];
        carry = sum9[8];
      end
      OpSub: begin
        sum9  = {1'b0, acc_q} - {1'b0, opb};
        res   = sum9[7:0];
        carry = sum9[8];
      end
      OpSbb: begin
        sum9  = {1'b0, acc_q} - {1'b0, opb} - {8'b0, c_q};
        res   = sum9[7:0];
        carry = sum9[8];
      end
      OpAnd:  res = acc_q & opb;
      OpOr:   res = acc_q | opb;
      OpXor:  res = acc_q ^ opb;
      OpNot:  res = ~acc_q;
      OpShl: begin
        res   = {acc_q[6:0], 1'b0};
        carry = acc_q[7];
      end
      OpShr: begin
        res   = {1'b0, acc_q[7:1]};
        carry = acc_q[0];
      end
      OpRol: begin
        res   = {acc_q[6:0], acc_q[7]};
        carry = acc_q[7];
      end
      OpRor: begin
        res   = {acc_q[0], acc_q[7:1]};
        carry = acc_q[0];
      end
      OpInc: begin
        sum9  = {1'b0, acc_q} + 9'd1;
        res   = sum9[7:0];
        carry = sum9[8];
      end
      OpClr: begin
        res   = 8'h00;
        carry = 1'b0;
      end
      default: upd_z = 1'b0;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    c_d   = c_q;
    z_d   = z_q;
    if (exec) begin
      acc_d = res;
      c_d   = carry;
      if (upd_z) z_d = (res == 8'h00);
    end
  end

  // stb_q resets high so a strobe held through reset release does not fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q  <= 1'b1;
      acc_q  <= 8'h00;
      c_q    <= 1'b0;
      z_q    <= 1'b1;
      done_q <= 1'b0;
    end else begin
      stb_q  <= stb;
      acc_q  <= acc_d;
      c_q    <= c_d;
      z_q    <= z_d;
      done_q <= exec;
    end
  end

  assign uo_out  = acc_q;
  assign uio_out = {c_q, z_q, done_q, 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_top.sv
// Randomised scoreboard bench for tt_um_top: driver pushes model results,
// a monitor pops and compares on every done pulse.
module tb_tt_um_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h10;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  // Reference state as plain integers.
  int ma = 0;
  int mc = 0;
  int mz = 1;

  tt_um_top dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    ma = 0;
    mc = 0;
    mz = 1;
  endtask

  task automatic model_step(input int op, input int b);
    int t;
    case (op)
      0: ;
      1: ma = b;
      2: begin t = ma + b; mc = (t > 255); ma = t % 256; end
      3: begin t = ma + b + mc; mc = (t > 255); ma = t % 256; end
      4: begin mc = (ma < b); ma = (ma - b) & 255; end
      5: begin t = ma - b - mc; mc = (ma < b + mc); ma = t & 255; end
      6: ma = ma & b;
      7: ma = ma | b;
      8: ma = ma ^ b;
      9: ma = 255 - ma;
      10: begin mc = ma / 128; ma = (ma * 2) % 256; end
      11: begin mc = ma % 2; ma = ma / 2; end
      12: begin mc = ma / 128; ma = (ma * 2) % 256 + mc; end
      13: begin mc = ma % 2; ma = ma / 2 + mc * 128; end
      14: begin mc = (ma == 255); ma = (ma + 1) % 256; end
      default: begin ma = 0; mc = 0; end
    endcase
    if (op != 0) mz = (ma == 0);
    exp_q.push_back({ma[7:0], mc[0], mz[0]});
  endtask

  // One strobe pulse; strobe is held for 1+hold edges, then released.
  task automatic do_op(input logic [3:0] op, input logic [7:0] b, input int hold);
    @(negedge clk);
    ui_in  = b;
    uio_in = {3'($urandom), 1'b1, op};
    @(posedge clk);
    model_step(int'(op), int'(b));
    repeat (hold) begin
      @(negedge clk);
      ui_in       = 8'($urandom);
      uio_in[7:5] = 3'($urandom);
    end
    @(negedge clk);
    uio_in[4] = 1'b0;
  endtask

  task automatic expect_state(input string name, input logic [7:0] a, input logic c,
                              input logic z);
    chk({name, ".a"}, 32'(uo_out), 32'(a));
    chk({name, ".c"}, 32'(uio_out[7]), 32'(c));
    chk({name, ".z"}, 32'(uio_out[6]), 32'(z));
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && uio_out[5]) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(uio_out[5]), 32'd0);
      end else begin
        chk("result", 32'({uo_out, uio_out[7], uio_out[6]}), 32'(exp_q.pop_front()));
        chk("uio_low", 32'(uio_out[4:0]), 32'd0);
      end
    end
  end

  initial begin
    int guard;
    // Reset with strobe high.
    repeat (3) @(negedge clk);
    chk("rst.uo_out", 32'(uo_out), 32'h00);
    chk("rst.uio_out", 32'(uio_out), 32'h40);
    chk("rst.uio_oe", 32'(uio_oe), 32'hE0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst.uio_out", 32'(uio_out), 32'h40);
    uio_in[4] = 1'b0;

    // LOAD / ADD overflow / ADC.
    do_op(4'h1, 8'hF0, 0);
    expect_state("load", 8'hF0, 1'b0, 1'b0);
    do_op(4'h2, 8'h20, 1);
    expect_state("add", 8'h10, 1'b1, 1'b0);
    do_op(4'h3, 8'h00, 0);
    expect_state("adc", 8'h11, 1'b0, 1'b0);

    // SUB borrow and zero.
    do_op(4'h1, 8'h05, 0);
    do_op(4'h4, 8'h06, 0);
    expect_state("sub_borrow", 8'hFF, 1'b1, 1'b0);
    do_op(4'h1, 8'h05, 0);
    do_op(4'h4, 8'h05, 0);
    expect_state("sub_zero", 8'h00, 1'b0, 1'b1);

    // Shifts and rotates.
    do_op(4'h1, 8'h81, 0);
    do_op(4'hC, 8'h00, 0);
    expect_state("rol", 8'h03, 1'b1, 1'b0);
    do_op(4'hD, 8'h00, 0);
    expect_state("ror", 8'h81, 1'b1, 1'b0);
    do_op(4'hB, 8'h00, 0);
    expect_state("shr", 8'h40, 1'b1, 1'b0);
    do_op(4'hA, 8'h00, 0);
    expect_state("shl", 8'h80, 1'b0, 1'b0);

    // Gating: strobe while disabled, then enable with strobe still high.
    @(negedge clk);
    ena    = 1'b0;
    uio_in = 8'h1E;
    repeat (3) @(negedge clk);
    chk("gated.uo_out", 32'(uo_out), 32'h80);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk("ena_rise.uo_out", 32'(uo_out), 32'h80);
    uio_in[4] = 1'b0;
    do_op(4'hE, 8'h00, 2);
    expect_state("inc_once", 8'h81, 1'b0, 1'b0);

    // Logic ops leave C alone; CLR clears everything.
    do_op(4'h1, 8'hFF, 0);
    do_op(4'hE, 8'h00, 0);
    do_op(4'h1, 8'h0F, 0);
    expect_state("load_keep_c", 8'h0F, 1'b1, 1'b0);
    do_op(4'h8, 8'h0F, 0);
    expect_state("xor", 8'h00, 1'b1, 1'b1);
    do_op(4'hF, 8'h00, 0);
    expect_state("clr", 8'h00, 1'b0, 1'b1);
    do_op(4'h0, 8'h55, 0);
    expect_state("nop", 8'h00, 1'b0, 1'b1);

    // Randomised ops.
    for (int i = 0; i < 300; i++) begin
      do_op(4'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset right after an executing edge kills the pending done pulse.
    do_op(4'h1, 8'h3C, 0);
    @(negedge clk);
    ui_in  = 8'hAA;
    uio_in = 8'h12;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.uo_out", 32'(uo_out), 32'h00);
    chk("mid_rst.uio_out", 32'(uio_out), 32'h40);
    exp_q.delete();
    model_reset();
    uio_in[4] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'hE, 8'h00, 0);
    expect_state("inc_after_rst", 8'h01, 1'b0, 1'b0);

    // Drain: every expected result must have been observed.
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
